div_8_8: RTL and testbench

Sequential unsigned divider, the inverse of the `mult_8_8` datapath: accepts a dividend/divisor pair over a valid/ready handshake, computes quotient and remainder by radix-2 restoring division (one quotient bit per cycle), and presents the result over a second valid/ready handshake. It sits downstream of the multiplier so that products can be reduced back to their factors, e.g. 54 / 27 = 2.

---
 rtl/div_8_8.sv | 133 +++++++++++++
 tb/tb_div_8_8.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_8_8.sv
// div_8_8 - sequential unsigned radix-2 restoring divider.
// It produces one quotient bit per clock, MSB first, and has valid/ready
// handshakes on both the operand side and the result side.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   in_valid     a/b valid
//   in_ready     divider idle, can accept an operation
//   a, b         dividend, divisor (WIDTH bits, unsigned)
//   out_valid    quot/rem/div_by_zero valid
//   out_ready    consumer accepts the result
//   quot, rem    floor(a/b), a mod b  (b==0: all ones, a)
//   div_by_zero  set together with the result when b was 0
module div_8_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend in, quotient bits shift in at LSB
  logic [WIDTH-1:0]   dsr_q, dsr_d;     // captured divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  // One iteration: the shifted remainder is always < 2*divisor, so it fits
  // WIDTH+1 bits. The extra top bit of diff acts as the borrow (sign).
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               qbit;
  logic [WIDTH:0]     prem_nxt;
  logic [WIDTH-1:0]   dvd_nxt;

  always_comb begin
    shifted  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dsr_q};
    qbit     = ~diff[WIDTH+1];
    prem_nxt = qbit ? diff[WIDTH:0] : shifted;
    dvd_nxt  = {dvd_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (b != '0) begin
            prem_d  = '0;
            dvd_d   = a;
            dsr_d   = b;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            quot_d  = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        prem_d = prem_nxt;
        dvd_d  = dvd_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = dvd_nxt;
          rem_d   = prem_nxt[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags are decoded straight from the state register.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8_8.sv
// Testbench for div_8_8. It runs directed cases and random cases, and
// compares each result with a reference built from plain integer / and %.
module tb_div_8_8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  div_8_8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a/b, measure latency, check result against the arithmetic
  // reference, then consume if consume==1.
  task automatic do_op(input int av, input int bv, input bit consume);
    int n;
    int eq, er, ez, el;
    if (bv == 0) begin
      eq = 255; er = av; ez = 1; el = 0;
    end else begin
      eq = av / bv; er = av % bv; ez = 0; el = W;
    end
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_op", int'(in_ready), 1);
    a = W'(av); b = W'(bv); in_valid = 1'b1;
    tick();                        // accepting edge
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check($sformatf("latency %0d/%0d", av, bv), n, el);
    check($sformatf("quot %0d/%0d", av, bv), int'(quot), eq);
    check($sformatf("rem %0d/%0d", av, bv), int'(rem), er);
    check($sformatf("dbz %0d/%0d", av, bv), int'(div_by_zero), ez);
    check("in_ready_in_done", int'(in_ready), 0);
    if (consume) begin
      out_ready = 1'b1;
      tick();                      // consumption edge
      out_ready = 1'b0;
      check("out_valid_after_consume", int'(out_valid), 0);
      check("in_ready_after_consume", int'(in_ready), 1);
    end
  endtask

  initial begin
    int av, bv, n;
    // Reset
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_valid", int'(out_valid), 0);
    check("rst quot", int'(quot), 0);
    check("rst rem", int'(rem), 0);
    check("rst dbz", int'(div_by_zero), 0);

    // Inverse of the multiplier, edge values
    do_op(54, 27, 1);
    do_op(54, 3, 1);
    do_op(255, 1, 1);
    do_op(5, 9, 1);
    do_op(255, 255, 1);
    do_op(200, 7, 1);

    // Divide by zero, then a normal op
    do_op(7, 0, 1);
    do_op(9, 3, 1);

    // Backpressure: result must hold while inputs toggle
    do_op(100, 9, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
      check("bp out_valid", int'(out_valid), 1);
      check("bp quot", int'(quot), 11);
      check("bp rem", int'(rem), 1);
      check("bp in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp consumed out_valid", int'(out_valid), 0);
    check("bp consumed in_ready", int'(in_ready), 1);

    // Reset on the 4th BUSY edge
    a = 8'd200; b = 8'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midrst busy", int'(in_ready), 0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst in_ready", int'(in_ready), 1);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst quot", int'(quot), 0);
    check("midrst rem", int'(rem), 0);
    check("midrst dbz", int'(div_by_zero), 0);
    n = 0;
    repeat (W + 2) begin
      tick();
      if (out_valid) n++;
    end
    check("midrst no stale result", n, 0);
    do_op(10, 3, 1);

    // Random ops, mixing in some zero divisors
    for (int i = 0; i < 40; i++) begin
      av = int'($urandom_range(0, 255));
      bv = (i % 8 == 3) ? 0 : int'($urandom_range(0, 255));
      do_op(av, bv, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
endmodule
